// File: rtl/pr_arb_enc.sv
// Registered N-way priority encoder / arbiter: fixed (highest index wins) or
// round-robin priority, with the grant held under a valid/ack handshake.
module pr_arb_enc #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in,
  input  logic         mode,
  input  logic         ack,
  output logic [W-1:0] out,
  output logic         valid,
  output logic         idle
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       state;
  logic [W-1:0] last;
  logic [W-1:0] base;
  logic [W-1:0] win;

  // Descending wrapped search starting just below base; the loop runs from the
  // lowest-priority candidate up so the last hit assigned is the winner.
  function automatic logic [W-1:0] pick(input logic [N-1:0] req, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic [W-1:0] idx;
    r = '0;
    for (int i = N; i >= 1; i--) begin
      idx = W'((int'(b) + N - i) % N);
      if (req[idx]) r = idx;
    end
    return r;
  endfunction

  // An accepted grant feeds its index straight in as the new base, so a
  // back-to-back arbitration already sees the updated pointer.
  always_comb begin
    base = '0;
    if (mode) base = (state == GRANT && ack) ? out : last;
    win = pick(in, base);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      out   <= '0;
      valid <= 1'b0;
      idle  <= 1'b1;
      last  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in != '0) begin
            out   <= win;
            valid <= 1'b1;
            idle  <= 1'b0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (ack) begin
            last <= out;
            if (in != '0) begin
              out <= win;
            end else begin
              valid <= 1'b0;
              idle  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pr_arb_enc.sv
// Self-checking bench for pr_arb_enc: directed scenarios plus randomized traffic
// compared against a behavioural arbitration model.
module tb_pr_arb_enc;

  localparam int N = 8;
  localparam int W = $clog2(N);

  logic         clk;
  logic         rst_n;
  logic [N-1:0] in;
  logic         mode;
  logic         ack;
  logic [W-1:0] out;
  logic         valid;
  logic         idle;

  int checks;
  int failures;

  int mout;
  int mlast;
  bit mvalid;

  pr_arb_enc #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .mode(mode), .ack(ack),
    .out(out), .valid(valid), .idle(idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Walk the indices L-1, L-2, ... wrapping past 0 and return the first requester.
  function automatic int model_win(input logic [N-1:0] req, input int l);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (l - k + N) % N;
      if (req[idx]) return idx;
    end
    return 0;
  endfunction

  // One rising edge: the model consumes the inputs present at that edge, then
  // outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      mout = 0; mvalid = 0; mlast = 0;
    end else if (!mvalid) begin
      if (in != '0) begin
        mout = model_win(in, mode ? mlast : 0);
        mvalid = 1;
      end
    end else if (ack) begin
      mlast = mout;
      if (in != '0) mout = model_win(in, mode ? mlast : 0);
      else mvalid = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in = 8'hFF; mode = 1'b0; ack = 1'b0;
    for (int e = 0; e < 2; e++) begin
      tick();
      checks++;
      if (out !== 3'd0 || valid !== 1'b0 || idle !== 1'b1) begin
        failures++;
        $display("[TB] FAIL reset_edge%0d: out=%0d valid=%b idle=%b, expected out=0 valid=0 idle=1", e, out, valid, idle);
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (out !== 3'd7 || valid !== 1'b1 || idle !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release: out=%0d valid=%b idle=%b, expected out=7 valid=1 idle=0", out, valid, idle);
    end
  endtask

  task automatic test_single_hot();
    logic [N-1:0] one;
    mode = 1'b0; ack = 1'b1;
    for (int k = 0; k < N; k++) begin
      one = '0;
      one[k] = 1'b1;
      in = one;
      tick();
      checks++;
      if (out !== W'(k) || valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL single_hot_%0d: out=%0d valid=%b, expected out=%0d valid=1", k, out, valid, k);
      end
    end
    in = '0;
    tick();
    checks++;
    if (valid !== 1'b0 || idle !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_hot_drain: valid=%b idle=%b, expected valid=0 idle=1", valid, idle);
    end
  endtask

  task automatic test_fixed_equiv();
    mode = 1'b0; ack = 1'b1; in = 8'b0010_1000;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (out !== 3'd5 || valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL fixed_equiv_c%0d: out=%0d valid=%b, expected out=5 valid=1", c, out, valid);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_seq[5] = '{5, 3, 0, 5, 3};
    rst_n = 1'b0; in = '0; ack = 1'b0; mode = 1'b1;
    tick();
    rst_n = 1'b1; in = 8'b0010_1001; ack = 1'b1;
    for (int g = 0; g < 5; g++) begin
      tick();
      checks++;
      if (out !== W'(exp_seq[g]) || valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL round_robin_g%0d: out=%0d valid=%b, expected out=%0d valid=1", g, out, valid, exp_seq[g]);
      end
    end
  endtask

  task automatic test_ack_hold();
    mode = 1'b0; in = '0; ack = 1'b1;
    tick();
    in = 8'b0001_0000; ack = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      if (c == 2) in = 8'b1000_0000;
      tick();
      checks++;
      if (out !== 3'd4 || valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL ack_hold_c%0d: out=%0d valid=%b, expected out=4 valid=1", c, out, valid);
      end
    end
    ack = 1'b1;
    tick();
    checks++;
    if (out !== 3'd7 || valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ack_release: out=%0d valid=%b, expected out=7 valid=1", out, valid);
    end
  endtask

  task automatic test_reset_midgrant();
    // Leave both out and the last-grant pointer at 5 before resetting.
    mode = 1'b1; ack = 1'b1; in = 8'b0010_0000;
    tick();
    tick();
    checks++;
    if (out !== 3'd5 || valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midgrant_setup: out=%0d valid=%b, expected out=5 valid=1", out, valid);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (out !== 3'd0 || valid !== 1'b0 || idle !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midgrant_reset: out=%0d valid=%b idle=%b, expected out=0 valid=0 idle=1", out, valid, idle);
    end
    rst_n = 1'b1; ack = 1'b0; in = 8'b0010_1000;
    tick();
    checks++;
    if (out !== 3'd5 || valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midgrant_rearb: out=%0d valid=%b, expected out=5 valid=1", out, valid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      in    = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
      mode  = ($urandom_range(0, 7) != 0) ? mode : ~mode;
      ack   = N'($urandom_range(0, 2)) != '0;
      tick();
      checks++;
      if (out !== W'(mout) || valid !== mvalid || idle !== !mvalid) begin
        failures++;
        $display("[TB] FAIL random_c%0d: out=%0d valid=%b idle=%b, expected out=%0d valid=%b idle=%b", c, out, valid, idle, mout, mvalid, !mvalid);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    mout = 0; mlast = 0; mvalid = 0;
    rst_n = 1'b0; in = '0; mode = 1'b0; ack = 1'b0;
    #2;
    test_reset();
    test_single_hot();
    test_fixed_equiv();
    test_round_robin();
    test_ack_hold();
    test_reset_midgrant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
